fall_event_fsm: RTL and testbench
=================================

Name: fall_event_fsm

Overview:
- Downstream consumer of the accelerometer magnitude-squared stage.
- Classifies the sample stream `mag_sq` / `mag_valid` into a fall event using three phases: free-fall (low magnitude), then impact (high magnitude), then post-impact stillness (magnitude near 1 g).
- On a confirmed fall it pulses `fall_detected`, latches `alarm` until software/host clears it, and counts events.
- All thresholds are in raw LSB² units (±2 g range, 16384 LSB/g, so 1 g² = 2^28).

Parameters:
- FF_THRESH, 32'd67108864, free-fall when mag_sq < this (0.5 g)
- IMPACT_THRESH, 32'd1677721600, impact when mag_sq >= this (2.5 g)
- STILL_LO, 32'd171798692, stillness band lower bound, inclusive (0.8 g)
- STILL_HI, 32'd386547056, stillness band upper bound, inclusive (1.2 g)
- FF_MIN_SAMPLES, 16, consecutive free-fall samples required (1..65535)
- IMPACT_WINDOW, 25, max samples after free-fall ends to see impact (1..65535)
- STILL_SAMPLES, 50, consecutive in-band samples required after impact (1..65535)
- STILL_TIMEOUT, 200, max samples in stillness check before abandoning (> STILL_SAMPLES)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- mag_valid  in  1  one-cycle strobe, mag_sq valid
- mag_sq  in  32  unsigned ax²+ay²+az²
- alarm_clr  in  1  clears latched alarm (level or pulse)
- fall_detected  out  1  one-cycle pulse on confirmed fall
- alarm  out  1  latched alarm level
- state_o  out  3  current state: IDLE=0, FREEFALL=1, IMPACT_WAIT=2, STILL_CHECK=3, ALARM=4
- fall_count  out  16  confirmed falls, saturates at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; outputs fall_detected=0, alarm=0, state_o=0, fall_count=0.
  - Internal counters ff_cnt, win_cnt, still_cnt and tmo_cnt cleared.
  - Reset mid-event abandons the event immediately.
- Evaluation timing:
  - State and counters change only on clk edges where mag_valid=1, except ALARM exit via alarm_clr.
  - All comparisons are unsigned 32-bit.
  - All outputs are registered. Decisions take effect on the edge that samples the deciding mag_valid, i.e. 1-cycle latency.
- IDLE:
  - Sample < FF_THRESH: ff_cnt<=1, go to FREEFALL.
  - Otherwise stay.
- FREEFALL:
  - Sample < FF_THRESH: ff_cnt++ (saturating).
  - Sample >= FF_THRESH with ff_cnt < FF_MIN_SAMPLES: go to IDLE.
  - Sample >= IMPACT_THRESH with ff_cnt >= FF_MIN_SAMPLES: go directly to STILL_CHECK (still_cnt=0, tmo_cnt=0).
  - Other sample >= FF_THRESH with ff_cnt >= FF_MIN_SAMPLES: go to IMPACT_WAIT with win_cnt<=1.
- IMPACT_WAIT:
  - Sample >= IMPACT_THRESH: go to STILL_CHECK, still_cnt=0, tmo_cnt=0.
  - Otherwise win_cnt++. When the incremented value equals IMPACT_WINDOW, go to IDLE.
  - A new free-fall sample does not restart the sequence.
- STILL_CHECK (tmo_cnt++ on every sample):
  - Sample in [STILL_LO, STILL_HI]: still_cnt++.
  - Sample outside the band: still_cnt<=0.
  - If still_cnt+1 == STILL_SAMPLES on an in-band sample: go to ALARM. The same edge sets fall_detected=1 for exactly one cycle, sets alarm=1, and increments fall_count (held at FFFF if already saturated).
  - Otherwise, if tmo_cnt+1 == STILL_TIMEOUT: go to IDLE. Stillness completion takes priority over timeout on the same sample.
- ALARM:
  - alarm stays 1 and mag_valid is ignored.
  - alarm_clr=1 on any edge: alarm<=0, go to IDLE. A simultaneous sample is discarded, not evaluated.
- alarm_clr outside ALARM is ignored.
- fall_detected is never high for two consecutive cycles.
- state_o always reflects the registered state.

Test Plan:
Sim overrides for all scenarios: FF_MIN_SAMPLES=3, IMPACT_WINDOW=4, STILL_SAMPLES=5, STILL_TIMEOUT=20; default thresholds; mag_valid every 4th clk.
- Nominal fall: 3×mag_sq=0x01000000, then 1×0x70000000, then 5×0x10000000 (1 g) -> state_o 0→1→3→4. fall_detected pulses 1 cycle on the 5th still sample edge, alarm=1, fall_count=1. Then alarm_clr -> alarm=0, state_o=0.
- Short free-fall: 2×0x01000000, then 0x10000000 -> FREEFALL→IDLE, no alarm, fall_count=0.
- Impact window expiry: 3×0x01000000, then 4×0x10000000 (no impact) -> IMPACT_WAIT for 3 samples, IDLE after the 4th. A 0x70000000 one sample later gives no STILL_CHECK.
- Stillness broken/timeout:
  - After impact: 4 in-band, 1×0x30000000, 5 in-band -> ALARM on 10th sample.
  - Alternating in/out samples -> IDLE after the 20th sample, no pulse.
- Boundaries:
  - mag_sq==FF_THRESH is not free-fall.
  - mag_sq==IMPACT_THRESH is impact.
  - mag_sq==STILL_LO and mag_sq==STILL_HI count as in-band.
- Reset and clear:
  - rst_n low during STILL_CHECK -> all outputs 0 asynchronously, IDLE.
  - In ALARM, alarm_clr coincident with an in-band mag_valid -> IDLE, sample ignored.
  - 65536 forced falls -> fall_count holds FFFF.

Source files
------------

// File: rtl/fall_event_fsm.sv
// fall_event_fsm: classifies a magnitude-squared stream into free-fall, impact and stillness phases
// and raises a latched alarm plus a one-cycle pulse on a confirmed fall.
module fall_event_fsm #(
  parameter logic [31:0] FF_THRESH      = 32'd67108864,
  parameter logic [31:0] IMPACT_THRESH  = 32'd1677721600,
  parameter logic [31:0] STILL_LO       = 32'd171798692,
  parameter logic [31:0] STILL_HI       = 32'd386547056,
  parameter int unsigned FF_MIN_SAMPLES = 16,
  parameter int unsigned IMPACT_WINDOW  = 25,
  parameter int unsigned STILL_SAMPLES  = 50,
  parameter int unsigned STILL_TIMEOUT  = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mag_valid,
  input  logic [31:0] mag_sq,
  input  logic        alarm_clr,
  output logic        fall_detected,
  output logic        alarm,
  output logic [2:0]  state_o,
  output logic [15:0] fall_count
);
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FREEFALL    = 3'd1,
    IMPACT_WAIT = 3'd2,
    STILL_CHECK = 3'd3,
    ALARM       = 3'd4
  } state_t;
  localparam logic [15:0] FF_MIN    = 16'(FF_MIN_SAMPLES);
  localparam logic [16:0] WIN_END   = 17'(IMPACT_WINDOW);
  localparam logic [16:0] STILL_END = 17'(STILL_SAMPLES);
  localparam logic [16:0] TMO_END   = 17'(STILL_TIMEOUT);
  state_t state, state_n;
  logic [15:0] ff_cnt, ff_n, win_cnt, win_n, still_cnt, still_n, tmo_cnt, tmo_n;
  logic [16:0] win_inc, still_inc, tmo_inc;
  logic is_ff, is_imp, in_band, fire;
  assign is_ff     = mag_sq < FF_THRESH;
  assign is_imp    = mag_sq >= IMPACT_THRESH;
  assign in_band   = (mag_sq >= STILL_LO) && (mag_sq <= STILL_HI);
  // 17-bit increments so the end-of-window compares never wrap at 65535
  assign win_inc   = {1'b0, win_cnt} + 17'd1;
  assign still_inc = {1'b0, still_cnt} + 17'd1;
  assign tmo_inc   = {1'b0, tmo_cnt} + 17'd1;
  assign state_o   = state;
  always_comb begin
    state_n = state;
    ff_n    = ff_cnt;
    win_n   = win_cnt;
    still_n = still_cnt;
    tmo_n   = tmo_cnt;
    fire    = 1'b0;
    if (state == ALARM) begin
      if (alarm_clr) state_n = IDLE;
    end else if (mag_valid) begin
      case (state)
        IDLE: begin
          if (is_ff) begin
            ff_n    = 16'd1;
            state_n = FREEFALL;
          end
        end
        FREEFALL: begin
          if (is_ff) ff_n = (ff_cnt == 16'hFFFF) ? ff_cnt : ff_cnt + 16'd1;
          else if (ff_cnt < FF_MIN) state_n = IDLE;
          else if (is_imp) begin
            state_n = STILL_CHECK;
            still_n = 16'd0;
            tmo_n   = 16'd0;
          end else begin
            state_n = IMPACT_WAIT;
            win_n   = 16'd1;
          end
        end
        IMPACT_WAIT: begin
          if (is_imp) begin
            state_n = STILL_CHECK;
            still_n = 16'd0;
            tmo_n   = 16'd0;
          end else begin
            win_n = win_inc[15:0];
            if (win_inc == WIN_END) state_n = IDLE;
          end
        end
        STILL_CHECK: begin
          tmo_n   = tmo_inc[15:0];
          still_n = in_band ? still_inc[15:0] : 16'd0;
          // completion wins over timeout on the same sample
          if (in_band && still_inc == STILL_END) begin
            state_n = ALARM;
            fire    = 1'b1;
          end else if (tmo_inc == TMO_END) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ff_cnt        <= 16'd0;
      win_cnt       <= 16'd0;
      still_cnt     <= 16'd0;
      tmo_cnt       <= 16'd0;
      fall_detected <= 1'b0;
      alarm         <= 1'b0;
      fall_count    <= 16'd0;
    end else begin
      state         <= state_n;
      ff_cnt        <= ff_n;
      win_cnt       <= win_n;
      still_cnt     <= still_n;
      tmo_cnt       <= tmo_n;
      fall_detected <= fire;
      alarm         <= fire ? 1'b1 : (state == ALARM && alarm_clr) ? 1'b0 : alarm;
      fall_count    <= (fire && fall_count != 16'hFFFF) ? fall_count + 16'd1 : fall_count;
    end
  end
endmodule

// File: tb/tb_fall_event_fsm.sv
// tb_fall_event_fsm: directed samples with expected responses queued; a monitor checks each evaluated edge.
module tb_fall_event_fsm;
  localparam logic [31:0] FF_T  = 32'd67108864;
  localparam logic [31:0] IMP_T = 32'd1677721600;
  localparam logic [31:0] S_LO  = 32'd171798692;
  localparam logic [31:0] S_HI  = 32'd386547056;
  localparam logic [31:0] L = 32'h01000000, G = 32'h10000000, I = 32'h70000000, O = 32'h30000000;
  typedef struct packed {
    logic [2:0]  st;
    logic        al;
    logic        fd;
    logic [15:0] cnt;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, mag_valid = 1'b0, alarm_clr = 1'b0;
  logic [31:0] mag_sq = 32'd0;
  logic fall_detected, alarm;
  logic [2:0] state_o;
  logic [15:0] fall_count;
  logic [15:0] exp_cnt = 16'd0;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  fall_event_fsm #(
    .FF_MIN_SAMPLES(3), .IMPACT_WINDOW(4), .STILL_SAMPLES(5), .STILL_TIMEOUT(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mag_valid(mag_valid), .mag_sq(mag_sq), .alarm_clr(alarm_clr),
    .fall_detected(fall_detected), .alarm(alarm), .state_o(state_o), .fall_count(fall_count)
  );
  always #5 clk = ~clk;
  function automatic void chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, got, exp);
    end
  endfunction
  // monitor: every edge that evaluates a sample or a clear consumes one expected record
  initial forever begin
    @(posedge clk);
    if (rst_n && (mag_valid || alarm_clr)) begin
      #1;
      if (q.size() == 0) chk("unexpected_event", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("state_o", 32'(state_o), 32'(e.st));
        chk("alarm", 32'(alarm), 32'(e.al));
        chk("fall_detected", 32'(fall_detected), 32'(e.fd));
        chk("fall_count", 32'(fall_count), 32'(e.cnt));
      end
    end else begin
      #1;
      if (fall_detected !== 1'b0) chk("fd_idle_edge", 32'(fall_detected), 32'd0);
    end
  end
  task automatic smp(input logic [31:0] v, input logic [2:0] st, input logic fd, input logic clr);
    repeat (3) @(negedge clk);
    if (fd) exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
    q.push_back('{st: st, al: (st == 3'd4), fd: fd, cnt: exp_cnt});
    mag_sq = v;
    mag_valid = 1'b1;
    alarm_clr = clr;
    @(negedge clk);
    mag_valid = 1'b0;
    alarm_clr = 1'b0;
  endtask
  task automatic clr_only();
    repeat (2) @(negedge clk);
    q.push_back('{st: 3'd0, al: 1'b0, fd: 1'b0, cnt: exp_cnt});
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
  endtask
  task automatic ff3_impact();
    repeat (3) smp(L, 3'd1, 1'b0, 1'b0);
    smp(I, 3'd3, 1'b0, 1'b0);
  endtask
  task automatic full_fall();
    ff3_impact();
    repeat (4) smp(G, 3'd3, 1'b0, 1'b0);
    smp(G, 3'd4, 1'b1, 1'b0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_count", 32'(fall_count), 32'd0);
    rst_n = 1'b1;
    // nominal fall, sample ignored in ALARM, clear
    full_fall();
    smp(L, 3'd4, 1'b0, 1'b0);
    clr_only();
    // clear outside ALARM is ignored; short free-fall
    smp(G, 3'd0, 1'b0, 1'b1);
    smp(L, 3'd1, 1'b0, 1'b0);
    smp(L, 3'd1, 1'b0, 1'b0);
    smp(G, 3'd0, 1'b0, 1'b0);
    // impact window expiry, late impact does nothing
    repeat (3) smp(L, 3'd1, 1'b0, 1'b0);
    repeat (3) smp(G, 3'd2, 1'b0, 1'b0);
    smp(G, 3'd0, 1'b0, 1'b0);
    smp(I, 3'd0, 1'b0, 1'b0);
    // stillness broken then completed on the 10th sample
    ff3_impact();
    smp(G, 3'd3, 1'b0, 1'b1);
    repeat (3) smp(G, 3'd3, 1'b0, 1'b0);
    smp(O, 3'd3, 1'b0, 1'b0);
    repeat (4) smp(G, 3'd3, 1'b0, 1'b0);
    smp(G, 3'd4, 1'b1, 1'b0);
    clr_only();
    // alternating in/out band times out on the 20th sample
    ff3_impact();
    for (int k = 0; k < 19; k++) smp((k % 2) ? O : G, 3'd3, 1'b0, 1'b0);
    smp(O, 3'd0, 1'b0, 1'b0);
    // threshold boundaries
    smp(FF_T, 3'd0, 1'b0, 1'b0);
    smp(FF_T - 32'd1, 3'd1, 1'b0, 1'b0);
    smp(L, 3'd1, 1'b0, 1'b0);
    smp(L, 3'd1, 1'b0, 1'b0);
    smp(IMP_T - 32'd1, 3'd2, 1'b0, 1'b0);
    smp(IMP_T, 3'd3, 1'b0, 1'b0);
    smp(S_LO, 3'd3, 1'b0, 1'b0);
    smp(S_HI, 3'd3, 1'b0, 1'b0);
    smp(S_LO - 32'd1, 3'd3, 1'b0, 1'b0);
    smp(S_HI + 32'd1, 3'd3, 1'b0, 1'b0);
    smp(S_LO, 3'd3, 1'b0, 1'b0);
    smp(S_HI, 3'd3, 1'b0, 1'b0);
    smp(S_LO, 3'd3, 1'b0, 1'b0);
    smp(S_HI, 3'd3, 1'b0, 1'b0);
    smp(S_LO, 3'd4, 1'b1, 1'b0);
    // clear coincident with a free-fall sample: sample discarded
    smp(L, 3'd0, 1'b0, 1'b1);
    smp(G, 3'd0, 1'b0, 1'b0);
    // direct impact out of free-fall via IMPACT_THRESH exactly
    repeat (3) smp(L, 3'd1, 1'b0, 1'b0);
    smp(IMP_T, 3'd3, 1'b0, 1'b0);
    smp(O, 3'd3, 1'b0, 1'b0);
    // saturation: preload the counter just below the limit
    repeat (4) @(negedge clk);
    force dut.fall_count = 16'hFFFE;
    @(negedge clk);
    release dut.fall_count;
    exp_cnt = 16'hFFFE;
    smp(G, 3'd3, 1'b0, 1'b0);
    repeat (3) smp(G, 3'd3, 1'b0, 1'b0);
    smp(G, 3'd4, 1'b1, 1'b0);
    clr_only();
    full_fall();
    clr_only();
    // async reset mid stillness
    ff3_impact();
    smp(G, 3'd3, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_alarm", 32'(alarm), 32'd0);
    chk("arst_fd", 32'(fall_detected), 32'd0);
    chk("arst_count", 32'(fall_count), 32'd0);
    exp_cnt = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    smp(G, 3'd0, 1'b0, 1'b0);
    full_fall();
    clr_only();
    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) chk("queue_drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
